uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

- Receive-side controller for the UART RX path.
- Owns the oversampling edge counter, the bit counter and the frame state machine.
- Drives the enables of the data sampler, deserializer, start/parity/stop checkers, and consumes their error flags.
- Issues a one-cycle `data_valid` per error-free frame.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per frame (LSB first)

Ports:
- clk  input  1  system clock, prescale × baud rate
- rst  input  1  reset; synchronous, active-high
- rx_in  input  1  serial line, idle high, already synchronized
- par_en  input  1  1 = frame carries a parity bit; must be stable while not IDLE
- prescale  input  6  oversampling ratio; legal values 8, 16, 32 (others undefined); stable while not IDLE
- strt_glitch  input  1  start checker result; read only while strt_chk_en=1
- par_err  input  1  parity checker result; read only while par_chk_en=1
- stop_err  input  1  stop checker result; read only while stop_chk_en=1
- edge_cnt  output  6  oversample index within current bit, 0..prescale-1
- bit_cnt  output  4  bit index within frame: 0 = start, 1..DATA_WIDTH = data, then parity/stop
- data_samp_en  output  1  sampler enable, high in every state except IDLE
- deser_en  output  1  one-cycle shift strobe, last edge of each data bit
- strt_chk_en  output  1  one-cycle strobe, last edge of start bit
- par_chk_en  output  1  one-cycle strobe, last edge of parity bit
- stop_chk_en  output  1  one-cycle strobe, last edge of stop bit
- data_valid  output  1  registered one-cycle pulse, frame accepted

## Operation
States: IDLE, START, DATA, PARITY, STOP.

Counters:
- edge_cnt and bit_cnt are registered.
- Both are held at 0 in IDLE and cleared on every transition into IDLE or START.
- Outside IDLE, edge_cnt increments each cycle.
- At edge_cnt == prescale-1 ("last edge"), edge_cnt wraps to 0 and bit_cnt increments.
- bit_cnt never exceeds DATA_WIDTH+2.

Enables:
- All check and deser strobes are combinational decodes of state & (edge_cnt == prescale-1).
- They are high for exactly that one cycle.
- Checker outputs are combinational and are read in the same cycle.

Transitions (all registered):
- IDLE: rx_in == 0 → START.
- START, last edge: strt_glitch=1 → IDLE (frame dropped); else → DATA.
- DATA, last edge with bit_cnt == DATA_WIDTH: → PARITY if par_en, else → STOP. Otherwise remain in DATA.
- PARITY, last edge: latch par_err into an internal par_flag; → STOP. A parity error does not abort the frame, so framing stays aligned.
- STOP, last edge: → IDLE. data_valid is set next edge iff stop_err=0 and par_flag=0.
- par_flag is cleared on entry to START.

Boundary cases:
- rx_in is ignored outside IDLE, including a low level during STOP.
- A second start edge is only recognised after returning to IDLE.
- Reset mid-frame: the next state is IDLE, with counters, par_flag and data_valid all 0. No strobe fires on the reset cycle.

## Timing
- Reset values: edge_cnt=0, bit_cnt=0; data_samp_en, deser_en, strt_chk_en, par_chk_en, stop_chk_en and data_valid all 0.
- Reference point: edge E is the clock edge at which IDLE samples rx_in=0. After E, state=START and edge_cnt=0.
- Bit n (start bit = 0) occupies the cycles between edges E+n·prescale and E+(n+1)·prescale.
- Its last-edge strobe is high in the cycle ending at E+(n+1)·prescale.
- Without parity, data_valid is high for the single cycle after edge E+(DATA_WIDTH+2)·prescale. With parity, after E+(DATA_WIDTH+3)·prescale.
- On that same edge the state returns to IDLE. The next frame may start one cycle later, giving a 1-cycle minimum inter-frame gap.
- deser_en fires exactly DATA_WIDTH times per completed frame, spaced prescale cycles apart.

## Test plan
- Reset, then 8N1 frame 0xA5 at prescale=8 → 8 deser_en pulses 8 cycles apart; stop_chk_en at cycle 79 after E; data_valid high only in cycle 80; state back to IDLE.
- Same frame at prescale=16 with par_en=1 and par_err=0 → par_chk_en at cycle 159, stop_chk_en at 175, data_valid at cycle 176.
- Start glitch: rx_in low for 3 cycles at prescale=8, strt_glitch=1 at last edge → IDLE after cycle 8; zero deser_en pulses, no data_valid.
- par_en=1 with par_err=1 → STOP still entered and stop_chk_en fires; no data_valid. A following clean frame yields data_valid (par_flag cleared).
- stop_err=1 at the stop strobe → no data_valid; the next frame, started 1 cycle after IDLE, is received normally.
- rst asserted at cycle 40 of a prescale=8 frame → next cycle IDLE with all outputs 0; rx_in held high afterwards gives no strobes.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//   Frame controller for the UART receive path. It owns the oversampling edge
//   counter, the bit counter and the frame FSM (IDLE/START/DATA/PARITY/STOP).
//   It strobes the sampler, deserializer and checkers, consumes their error
//   flags, and raises a one-cycle data_valid for each error-free frame.
//
// Ports
//   clk, rst      : clock (prescale x baud), synchronous active-high reset
//   rx_in         : synchronized serial line, idle high
//   par_en        : frame carries a parity bit (stable while not IDLE)
//   prescale      : oversampling ratio 8/16/32 (stable while not IDLE)
//   strt_glitch   : start checker result, read while strt_chk_en=1
//   par_err       : parity checker result, read while par_chk_en=1
//   stop_err      : stop checker result, read while stop_chk_en=1
//   edge_cnt      : oversample index within the current bit
//   bit_cnt       : bit index within frame (0 = start, 1..DATA_WIDTH = data)
//   data_samp_en  : sampler enable, high outside IDLE
//   deser_en      : shift strobe on the last edge of each data bit
//   strt_chk_en   : strobe on the last edge of the start bit
//   par_chk_en    : strobe on the last edge of the parity bit
//   stop_chk_en   : strobe on the last edge of the stop bit
//   data_valid    : registered one-cycle frame-accepted pulse
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stop_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       data_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stop_chk_en,
    output logic       data_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_t     state_q, state_d;
    logic [5:0] edge_cnt_q, edge_cnt_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       par_flag_q, par_flag_d;
    logic       data_valid_q, data_valid_d;
    logic       last_edge;

    // Raw decodes before reset gating.
    logic samp_en_c, deser_c, strt_c, par_c, stop_c;

    assign last_edge = (edge_cnt_q == (prescale - 6'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            par_flag_q   <= par_flag_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q + 6'd1;
        bit_cnt_d    = bit_cnt_q;
        par_flag_d   = par_flag_q;
        data_valid_d = 1'b0;
        samp_en_c    = (state_q != S_IDLE);
        deser_c      = 1'b0;
        strt_c       = 1'b0;
        par_c        = 1'b0;
        stop_c       = 1'b0;

        // Bit boundary: wrap oversample index, advance bit index.
        if (last_edge) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!rx_in) begin
                    state_d    = S_START;
                    par_flag_d = 1'b0;
                end
            end
            S_START: begin
                if (last_edge) begin
                    strt_c = 1'b1;
                    if (strt_glitch) begin
                        state_d    = S_IDLE;
                        edge_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_edge) begin
                    deser_c = 1'b1;
                    if (bit_cnt_q == LAST_DATA_BIT)
                        state_d = par_en ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                // A parity error is only remembered; the frame runs to its
                // stop bit so the receiver stays aligned to the line.
                if (last_edge) begin
                    par_c      = 1'b1;
                    par_flag_d = par_err;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (last_edge) begin
                    stop_c       = 1'b1;
                    state_d      = S_IDLE;
                    edge_cnt_d   = '0;
                    bit_cnt_d    = '0;
                    data_valid_d = !stop_err && !par_flag_q;
                end
            end
            default: begin
                state_d    = S_IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // Strobes are suppressed while rst is high so a reset landing on a last
    // edge cannot leak a shift or check pulse into the datapath.
    assign data_samp_en = samp_en_c & ~rst;
    assign deser_en     = deser_c   & ~rst;
    assign strt_chk_en  = strt_c    & ~rst;
    assign par_chk_en   = par_c     & ~rst;
    assign stop_chk_en  = stop_c    & ~rst;
    assign data_valid   = data_valid_q;
    assign edge_cnt     = edge_cnt_q;
    assign bit_cnt      = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic       strt_glitch = 1'b0;
    logic       par_err = 1'b0;
    logic       stop_err = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       data_samp_en, deser_en, strt_chk_en, par_chk_en, stop_chk_en, data_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int ps[3]    = '{8, 16, 32};

    uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stop_err(stop_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .data_samp_en(data_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stop_chk_en(stop_chk_en), .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_edge, input int e_bit,
                           input bit samp, input bit des, input bit st,
                           input bit pa, input bit sp, input bit dv);
        chk({tag, ".edge_cnt"},     32'(edge_cnt),     32'(e_edge));
        chk({tag, ".bit_cnt"},      32'(bit_cnt),      32'(e_bit));
        chk({tag, ".data_samp_en"}, 32'(data_samp_en), 32'(samp));
        chk({tag, ".deser_en"},     32'(deser_en),     32'(des));
        chk({tag, ".strt_chk_en"},  32'(strt_chk_en),  32'(st));
        chk({tag, ".par_chk_en"},   32'(par_chk_en),   32'(pa));
        chk({tag, ".stop_chk_en"},  32'(stop_chk_en),  32'(sp));
        chk({tag, ".data_valid"},   32'(data_valid),   32'(dv));
    endtask

    // Idle line for n cycles: every output must stay quiet.
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_in       = 1'b1;
            strt_glitch = 1'($urandom);
            par_err     = 1'($urandom);
            stop_err    = 1'($urandom);
            #1;
            chk_all($sformatf("%s.idle%0d", tag, i), 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    // One frame. Called just after a negedge in an IDLE cycle; pulling rx_in
    // low here makes the next posedge the start edge E. Cycle k is the cycle
    // between edges E+k and E+k+1, so bit n = k/P and its last edge is
    // k%P == P-1. Expectations come straight from that arithmetic. Returns
    // just after the check of the first IDLE cycle, so a following call
    // starts the next frame with a one-cycle gap.
    task automatic frame(input string tag, input int P, input bit pe, input bit perr,
                         input bit serr, input bit glitch, input logic [7:0] d,
                         input int rst_at);
        int  nbits, len, n, desers;
        bit  last, e_des, e_st, e_pa, e_sp, e_dv;
        logic [7:0] dat;
        dat    = d;
        nbits  = DW + 2 + (pe ? 1 : 0);
        len    = glitch ? P : nbits * P;
        desers = 0;
        prescale = 6'(P);
        par_en   = pe;
        rx_in    = 1'b0;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            n    = k / P;
            last = (k % P) == (P - 1);
            if (k < len) begin
                e_des = last && !glitch && n >= 1 && n <= DW;
                e_st  = last && n == 0;
                e_pa  = last && !glitch && pe && n == DW + 1;
                e_sp  = last && !glitch && n == nbits - 1;
            end else begin
                e_des = 0; e_st = 0; e_pa = 0; e_sp = 0;
            end
            e_dv = (k == len) && !glitch && !serr && !(pe && perr);
            // Line level: start low (only 3 cycles for a glitch), data LSB
            // first, even parity, then stop/idle high.
            if (glitch)                 rx_in = (k < 3) ? 1'b0 : 1'b1;
            else if (k >= len)          rx_in = 1'b1;
            else if (n == 0)            rx_in = 1'b0;
            else if (n <= DW)           rx_in = dat[n-1];
            else if (pe && n == DW + 1) rx_in = ^dat;
            else                        rx_in = 1'b1;
            // Checker results only carry meaning in their strobe cycle.
            strt_glitch = e_st ? glitch : 1'($urandom);
            par_err     = e_pa ? perr   : 1'($urandom);
            stop_err    = e_sp ? serr   : 1'($urandom);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk({tag, ".rstcyc.samp"},  32'(data_samp_en), 0);
                chk({tag, ".rstcyc.deser"}, 32'(deser_en), 0);
                chk({tag, ".rstcyc.strt"},  32'(strt_chk_en), 0);
                chk({tag, ".rstcyc.stop"},  32'(stop_chk_en), 0);
                @(negedge clk);
                rst   = 1'b0;
                rx_in = 1'b1;
                #1;
                chk_all({tag, ".postrst"}, 0, 0, 0, 0, 0, 0, 0, 0);
                return;
            end
            #1;
            if (deser_en === 1'b1) desers++;
            if (k < len)
                chk_all($sformatf("%s.k%0d", tag, k), k % P, n, 1, e_des, e_st, e_pa, e_sp, 0);
            else
                chk_all($sformatf("%s.end", tag), 0, 0, 0, 0, 0, 0, 0, e_dv);
        end
        chk({tag, ".deser_count"}, 32'(desers), glitch ? 0 : DW);
    endtask

    initial begin
        int P;
        bit pe, perr, serr, gl;
        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(4, "post_reset");

        // 8N1 0xA5 at prescale 8.
        frame("f8n1", 8, 0, 0, 0, 0, 8'hA5, -1);
        idle(2, "g1");
        // 0xA5 at prescale 16 with clean parity.
        frame("f16p", 16, 1, 0, 0, 0, 8'hA5, -1);
        idle(2, "g2");
        // Start glitch.
        frame("glitch", 8, 0, 0, 0, 1, 8'h00, -1);
        idle(2, "g3");
        // Parity error, then back-to-back clean frame (flag must clear).
        frame("perr", 8, 1, 1, 0, 0, 8'h3C, -1);
        frame("perr_next", 8, 1, 0, 0, 0, 8'hC3, -1);
        idle(1, "g4");
        // Stop error, then back-to-back clean frame.
        frame("serr", 8, 0, 0, 1, 0, 8'h5A, -1);
        frame("serr_next", 8, 0, 0, 0, 0, 8'h81, -1);
        // Reset mid-frame at cycle 40, and on a deser strobe cycle (39).
        frame("rst40", 8, 0, 0, 0, 0, 8'hFF, 40);
        idle(20, "after_rst40");
        frame("rst39", 8, 1, 0, 0, 0, 8'h0F, 39);
        idle(3, "after_rst39");
        frame("after_rst", 32, 0, 0, 0, 0, 8'h77, -1);

        // Randomized frames.
        for (int i = 0; i < 20; i++) begin
            P    = ps[$urandom_range(0, 2)];
            pe   = 1'($urandom);
            perr = ($urandom_range(0, 3) == 0);
            serr = ($urandom_range(0, 3) == 0);
            gl   = ($urandom_range(0, 7) == 0);
            frame($sformatf("rnd%0d", i), P, pe, perr, serr, gl, 8'($urandom), -1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4), $sformatf("rg%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
